// File: rtl/sync_fifo_prog_pkg.sv
// Shared types and constants for the programmable-flag synchronous FIFO.
// Provides the pointer-width helper, the flag bundle and the flag reset values.
package fifo_pkg;

  // Pointer and count width: one extra bit over the address to tell full from empty
  function automatic int ptr_w(input int addr_width);
    return addr_width + 1;
  endfunction

  // All registered fill/drain flags kept together so they update as one unit
  typedef struct packed {
    logic full;
    logic almost_full;
    logic prog_full;
    logic empty;
    logic almost_empty;
    logic prog_empty;
  } fifo_flags_t;

  localparam logic FULL_RST         = 1'b0;
  localparam logic ALMOST_FULL_RST  = 1'b0;
  localparam logic PROG_FULL_RST    = 1'b0;
  localparam logic EMPTY_RST        = 1'b1;
  localparam logic ALMOST_EMPTY_RST = 1'b1;
  localparam logic PROG_EMPTY_RST   = 1'b1;

  localparam fifo_flags_t FLAGS_RST = '{
    full:         FULL_RST,
    almost_full:  ALMOST_FULL_RST,
    prog_full:    PROG_FULL_RST,
    empty:        EMPTY_RST,
    almost_empty: ALMOST_EMPTY_RST,
    prog_empty:   PROG_EMPTY_RST
  };

endpackage

// File: rtl/sync_fifo_prog_if.sv
// Bus bundle for sync_fifo_prog: control/data in, data/flags out.
// master = the block feeding and draining the FIFO, slave = the FIFO itself.
interface sync_fifo_prog_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  clr;
  logic [DATA_WIDTH-1:0] din;
  logic                  wr_en;
  logic                  rd_en;
  logic [ADDR_WIDTH:0]   af_thresh;
  logic [ADDR_WIDTH:0]   ae_thresh;
  logic [DATA_WIDTH-1:0] dout;
  logic                  valid;
  logic                  full;
  logic                  almost_full;
  logic                  prog_full;
  logic                  empty;
  logic                  almost_empty;
  logic                  prog_empty;
  logic [ADDR_WIDTH:0]   data_count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output clr, din, wr_en, rd_en, af_thresh, ae_thresh,
    input  dout, valid, full, almost_full, prog_full,
    input  empty, almost_empty, prog_empty, data_count, overflow, underflow
  );

  modport slave (
    input  clr, din, wr_en, rd_en, af_thresh, ae_thresh,
    output dout, valid, full, almost_full, prog_full,
    output empty, almost_empty, prog_empty, data_count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_prog_mem.sv
// FIFO storage: DEPTH x DATA_WIDTH array, one synchronous write port and
// one asynchronous read port. Contents are never reset.
module fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Store write data at the write address on an accepted write
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/sync_fifo_prog.sv
// Synchronous FIFO with occupancy count, runtime-programmable thresholds,
// synchronous flush and FWFT/standard read modes.
// Optional feature macro: FIFO_ERR_FLAG_EN enables sticky overflow/underflow
// detection; without it both error outputs are tied low.
module sync_fifo_prog
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FWFT_EN    = 1
) (
  input logic             clk,
  input logic             rst_n,
  sync_fifo_prog_if.slave bus
);
  localparam int PW = ptr_w(ADDR_WIDTH);
  typedef logic [PW-1:0] fifo_ptr_t;

  localparam fifo_ptr_t DEPTH_C     = fifo_ptr_t'(2 ** ADDR_WIDTH);
  localparam fifo_ptr_t AFULL_LVL   = fifo_ptr_t'(2 ** ADDR_WIDTH - 1);
  localparam fifo_ptr_t AEMPTY_LVL  = fifo_ptr_t'(1);

  fifo_ptr_t   wptr_q, wptr_d;
  fifo_ptr_t   rptr_q, rptr_d;
  fifo_ptr_t   count_q, count_d;
  fifo_flags_t flags_q, flags_d;
  logic [DATA_WIDTH-1:0] dout_q;
  logic [DATA_WIDTH-1:0] rdata;
  logic wr_acc;
  logic rd_acc;

  // Writes into a full FIFO and reads from an empty one are simply refused
  assign wr_acc = bus.wr_en & ~flags_q.full;
  assign rd_acc = bus.rd_en & ~flags_q.empty;

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_acc & ~bus.clr),
    .waddr_i (wptr_q[ADDR_WIDTH-1:0]),
    .wdata_i (bus.din),
    .raddr_i (rptr_q[ADDR_WIDTH-1:0]),
    .rdata_o (rdata)
  );

  // Next pointers/count, and flags computed from the next count so they line up with it
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    flags_d = FLAGS_RST;
    if (bus.clr) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (wr_acc) wptr_d = wptr_q + fifo_ptr_t'(1);
      if (rd_acc) rptr_d = rptr_q + fifo_ptr_t'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + fifo_ptr_t'(1);
        2'b01:   count_d = count_q - fifo_ptr_t'(1);
        default: count_d = count_q;
      endcase
      flags_d.full         = (count_d == DEPTH_C);
      flags_d.almost_full  = (count_d >= AFULL_LVL);
      flags_d.empty        = (count_d == '0);
      flags_d.almost_empty = (count_d <= AEMPTY_LVL);
      flags_d.prog_full    = (count_d >= bus.af_thresh);
      flags_d.prog_empty   = (count_d <= bus.ae_thresh);
    end
  end

  // Pointer, count and flag state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      flags_q <= FLAGS_RST;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      flags_q <= flags_d;
    end
  end

  // Last word read: the standard-mode output register and the FWFT hold value when empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= '0;
    end else if (rd_acc && !bus.clr) begin
      dout_q <= rdata;
    end
  end

  generate
    if (FWFT_EN != 0) begin : g_fwft
      assign bus.valid = ~flags_q.empty;
      assign bus.dout  = flags_q.empty ? dout_q : rdata;
    end else begin : g_std
      logic valid_q;
      // One-cycle strobe marking the data loaded by an accepted read
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_q <= 1'b0;
        end else if (bus.clr) begin
          valid_q <= 1'b0;
        end else begin
          valid_q <= rd_acc;
        end
      end
      assign bus.valid = valid_q;
      assign bus.dout  = dout_q;
    end
  endgenerate

`ifdef FIFO_ERR_FLAG_EN
  logic overflow_q;
  logic underflow_q;

  // Sticky error flags: set by refused requests, cleared only by flush or reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (bus.clr) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.wr_en && flags_q.full)  overflow_q  <= 1'b1;
      if (bus.rd_en && flags_q.empty) underflow_q <= 1'b1;
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`else
  assign bus.overflow  = 1'b0;
  assign bus.underflow = 1'b0;
`endif

  assign bus.full         = flags_q.full;
  assign bus.almost_full  = flags_q.almost_full;
  assign bus.prog_full    = flags_q.prog_full;
  assign bus.empty        = flags_q.empty;
  assign bus.almost_empty = flags_q.almost_empty;
  assign bus.prog_empty   = flags_q.prog_empty;
  assign bus.data_count   = count_q;
endmodule

// File: doc/sync_fifo_prog.md
# sync_fifo_prog

Parametrised synchronous FIFO that succeeds the team's basic FIFO. It adds an occupancy count, runtime-programmable threshold flags, a synchronous flush, a valid strobe for standard-mode reads, and optional sticky overflow/underflow error flags. It sits between the port-side ingress logic and the shared cache write path, and serves as the per-port elastic buffer throughout the multi-port cache.

## Interface
Parameters:
- DATA_WIDTH, 8: width of din/dout.
- ADDR_WIDTH, 4: log2 of depth; DEPTH = 2**ADDR_WIDTH. Legal range is 1..12.
- FWFT_EN, 1: 1 = first-word fall-through; 0 = standard read with 1-cycle latency.

Ports:
- clk, input, 1: single clock; all logic on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- clr, input, 1: synchronous flush.
- din, input, DATA_WIDTH: write data.
- wr_en, input, 1: write request.
- rd_en, input, 1: read request / acknowledge.
- af_thresh, input, ADDR_WIDTH+1: prog_full threshold.
- ae_thresh, input, ADDR_WIDTH+1: prog_empty threshold.
- dout, output, DATA_WIDTH: read data.
- valid, output, 1: dout holds newly read data.
- full, almost_full, prog_full, output, 1 each: fill flags.
- empty, almost_empty, prog_empty, output, 1 each: drain flags.
- data_count, output, ADDR_WIDTH+1: occupancy, 0..DEPTH.
- overflow, underflow, output, 1 each: sticky error flags.

## Operation
- Pointers wptr and rptr are ADDR_WIDTH+1 bits and wrap modulo 2*DEPTH. The memory address is the low ADDR_WIDTH bits.
- A write is accepted when wr_en & ~full. A read is accepted when rd_en & ~empty. Requests that are not accepted have no effect on state.
- Simultaneous accepted read and write: both pointers advance and data_count is unchanged.
- Write while full: dropped, even if a read is accepted in the same cycle. There is no pass-through.
- Read and write while empty: only the write is accepted.
- data_count updates as follows: +1 for write only, -1 for read only, otherwise hold.
- All flags are registered and derived from the next-state count:
  - full: count == DEPTH.
  - almost_full: count >= DEPTH-1.
  - empty: count == 0.
  - almost_empty: count <= 1.
  - prog_full: count >= af_thresh.
  - prog_empty: count <= ae_thresh.
- Threshold values outside 0..DEPTH are legal and compare as unsigned.
- Flush: clr has priority over wr_en and rd_en. It resets pointers and count to 0, sets flags to their reset values, drives valid to 0, and clears the sticky error flags. dout holds its value.
- FWFT_EN=1:
  - dout = mem[raddr] combinationally whenever ~empty.
  - When empty, dout holds the last value that was read.
  - valid = ~empty.
- FWFT_EN=0:
  - dout is registered and loads mem[raddr] on an accepted read.
  - Otherwise dout holds its value; it is never zeroed.
  - valid is a 1-cycle pulse following each accepted read.

## Timing
- Reset values:
  - full, almost_full: 0.
  - empty, almost_empty: 1.
  - prog_empty: 1.
  - prog_full: 0.
  - data_count, dout, valid, overflow, underflow: 0.
  - Pointers: 0.
- Reset asserted mid-operation clears all state immediately. Memory contents are not reset.
- Write-to-read latency, FWFT: data written in cycle N is on dout, with empty=0, in cycle N+1.
- Write-to-read latency, standard: the earliest read is accepted in N+1, and data plus valid appear in N+2.
- Flag latency: every flag and data_count reflects an accepted operation in the cycle after it.
- Threshold latency: an af_thresh/ae_thresh change is reflected at the next clock edge.

## Configuration
- FIFO_ERR_FLAG_EN defined:
  - overflow sets on wr_en & full.
  - underflow sets on rd_en & empty.
  - Both flags are sticky until clr or reset, and assert the cycle after the offending request.
- FIFO_ERR_FLAG_EN undefined: overflow and underflow are tied to 0 and no detection logic is generated. Ports are present in both builds.

## Structure
- Package fifo_pkg holds:
  - fifo_ptr_t, parametrised via a typedef in the module from the package function ptr_w(ADDR_WIDTH).
  - The reset-value constants for the flags.
- Sub-module fifo_mem:
  - DEPTH x DATA_WIDTH register array, synthesis attribute ram_style "block".
  - One synchronous write port and one asynchronous read port.
  - The FIFO controller owns the pointers, count, flags and output stage.

## Test plan
- Fill/drain: DATA_WIDTH=8, ADDR_WIDTH=4, FWFT. Write 0x00..0x0F, then read all 16.
  - After write 15: almost_full=1. After write 16: full=1.
  - Writing 0xAA while full: dropped and data_count stays 16. With FIFO_ERR_FLAG_EN, overflow=1.
  - Reads return 0x00..0x0F in order, then empty=1.
- Simultaneous read/write at count 8 for 20 cycles: data_count stays 8, and output order matches a scoreboard across the pointer wrap.
- Standard mode: write 0x5A, then assert rd_en.
  - dout=0x5A with valid=1 exactly one cycle after the accepted read.
  - valid=0 on the next cycle, and dout still reads 0x5A.
- Programmable flags: af_thresh=12, ae_thresh=3.
  - prog_full rises on the 12th write and falls when count reaches 11.
  - prog_empty falls when count reaches 4.
- Flush: at count 9, assert clr together with wr_en.
  - Next cycle: data_count=0, empty=1, the write is ignored, and overflow/underflow are cleared.
- Reset mid-burst: deassert rst_n asynchronously mid-write.
  - All outputs go to their reset values at once.
  - After release, a write of 0x33 is read back correctly.
